bus_host_arbiter: RTL and testbench
===================================

Name: bus_host_arbiter

Overview:
- Round-robin arbiter that shares one downstream bus host port between NrHosts requesters, e.g. core data port, debug SBA and a future DMA engine.
- Forwards one request at a time and records the winning host ID in an in-order FIFO.
- Routes each downstream response back to the host that issued it.
- Sits between the requesters and a single host slot of the system bus.

Parameters:
- NrHosts, 3, number of upstream requesters (at least 1).
- AddrWidth, 32, address width.
- DataWidth, 32, data width.
- MaxOutstanding, 2, depth of the response-ID FIFO (at least 1).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- host_req_i  in  1 per host (unpacked [NrHosts])  request.
- host_gnt_o  out  1 per host  grant.
- host_addr_i  in  AddrWidth per host  address.
- host_we_i  in  1 per host  write enable.
- host_be_i  in  DataWidth/8 per host  byte enables.
- host_wdata_i  in  DataWidth per host  write data.
- host_rvalid_o  out  1 per host  response valid.
- host_rdata_o  out  DataWidth per host  read data.
- host_err_o  out  1 per host  response error.
- dev_req_o  out  1  downstream request.
- dev_gnt_i  in  1  downstream grant.
- dev_addr_o  out  AddrWidth  downstream address.
- dev_we_o  out  1  downstream write enable.
- dev_be_o  out  DataWidth/8  downstream byte enables.
- dev_wdata_o  out  DataWidth  downstream write data.
- dev_rvalid_i  in  1  downstream response valid.
- dev_rdata_i  in  DataWidth  downstream read data.
- dev_err_i  in  1  downstream response error.
- outstanding_o  out  $clog2(MaxOutstanding+1)  number of accepted, unanswered transactions.
- unexpected_rvalid_o  out  1  sticky flag: rvalid arrived with FIFO empty.

Interface:
- One clock, clk_i.
- Reset rst_i is synchronous and active-high. All state clears on the clk_i edge where rst_i=1.

Behaviour:
- Reset values:
  - Priority pointer = 0; state = ARB; FIFO empty.
  - outstanding_o = 0; unexpected_rvalid_o = 0.
  - All host_gnt_o, host_rvalid_o, host_err_o and dev_req_o = 0; data outputs = 0.
- Protocol: host request fields must stay stable from req until gnt. A host may not withdraw req before gnt.
- States:
  - ARB: winner = first asserted host_req_i scanning ptr, ptr+1, … mod NrHosts.
  - HOLD: winner = registered hold_id.
- Request forwarding:
  - dev_req_o = winner valid & ~fifo_full.
  - dev_addr/we/be/wdata = winner's fields, zero-cycle combinational.
- Grant: host_gnt_o[winner] = dev_gnt_i & dev_req_o. All other grants are 0.
- ARB -> HOLD: dev_req_o=1 and dev_gnt_i=0. Register hold_id = winner; the winner cannot change until granted.
- HOLD -> ARB: on dev_gnt_i.
- On handshake (dev_req_o & dev_gnt_i):
  - Push winner ID into the FIFO.
  - ptr <= (winner+1) mod NrHosts, with explicit wrap for non-power-of-2 NrHosts.
- Back-to-back: a new handshake is allowed every cycle while the FIFO is not full.
- FIFO full: dev_req_o=0 and the state holds, even if the current winner is in HOLD. Forwarding resumes the cycle after a pop frees a slot.
- Response routing, combinational and same-cycle:
  - On dev_rvalid_i with FIFO non-empty: host_rvalid_o[head]=1; host_rdata_o[head]=dev_rdata_i; host_err_o[head]=dev_err_i; pop.
  - Non-head hosts see rvalid=0, rdata=0, err=0.
- Simultaneous push and pop: both happen; outstanding_o is unchanged. Allowed when full only if the pop frees a slot, but dev_req_o still uses the registered full flag.
- Unexpected response: dev_rvalid_i with FIFO empty is dropped and sets unexpected_rvalid_o (cleared only by reset).
- Reset mid-transaction: FIFO and state clear. Any in-flight response arriving after reset is treated as unexpected.
- NrHosts=1: pointer is constant 0; behaviour is otherwise identical.

Decomposition:
- Package bus_host_arbiter_pkg: arb_state_e {ARB, HOLD}; function rr_next(ptr, NrHosts); IdWidth = $clog2(NrHosts) with minimum 1.
- Sub-module bus_arb_id_fifo: synchronous FIFO of IdWidth entries, MaxOutstanding deep.
  - Ports: clk_i, rst_i, push, pop, wdata, rdata, full, empty, count.

Test Plan:
- Reset check: drive rst_i=1 for 2 cycles with host_req_i all 1 -> all gnt=0, dev_req_o=0, outstanding_o=0.
- Round-robin fairness: hosts 0,1,2 request continuously, dev_gnt_i=1, rvalid returned 1 cycle later -> grant order 0,1,2,0,1,2; each response routed to the issuing host with rdata = 32'hA000_000<id>.
- Stall hold: host1 alone requests and dev_gnt_i=0 for 3 cycles, then host0 raises req, then gnt -> host1 granted first (HOLD); dev_addr_o stays host1's address throughout.
- FIFO full: MaxOutstanding=2, two grants with no rvalid -> dev_req_o=0 and outstanding_o=2. One rvalid -> outstanding_o=1 and dev_req_o=1 the next cycle.
- Simultaneous push/pop: with 1 outstanding for host2, host0 is granted in the same cycle rvalid returns with dev_err_i=1 -> host2 gets rvalid=1 and err=1; outstanding_o stays 1; next rvalid goes to host0.
- Unexpected response: dev_rvalid_i=1 with FIFO empty -> no host_rvalid_o; unexpected_rvalid_o=1 and stays 1 until rst_i.

Source files
------------

// File: rtl/bus_host_arbiter_pkg.sv
// bus_host_arbiter_pkg
// Shared types and helpers for the bus host arbiter and its response-ID FIFO.
//   arb_state_e   : arbiter FSM states (ARB = free arbitration, HOLD = winner locked)
//   calc_id_width : width of a host ID, never less than one bit
//   rr_next       : increment with explicit wrap, safe for non-power-of-2 sizes
package bus_host_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic int unsigned calc_id_width(input int unsigned nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nr_hosts);
        return (ptr + 1 >= nr_hosts) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// bus_arb_id_fifo
// Synchronous in-order FIFO holding the host ID of every accepted, unanswered
// downstream transaction.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   push, wdata  : enqueue wdata (accepted when not full, or when popping too)
//   pop, rdata   : dequeue head (ignored when empty); rdata shows the head
//   full, empty  : occupancy flags derived from the registered count
//   count        : number of stored entries
module bus_arb_id_fifo
    import bus_host_arbiter_pkg::*;
#(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 2,
    localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic                  pop,
    input  logic [Width-1:0]      wdata,
    output logic [Width-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [CountWidth-1:0] count
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]      mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CountWidth-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count_q == CountWidth'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the same cycle frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy count; pointers wrap explicitly so any
    // depth works, not just powers of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= PtrWidth'(rr_next(32'(wr_ptr_q), Depth));
            end
            if (do_pop) begin
                rd_ptr_q <= PtrWidth'(rr_next(32'(rd_ptr_q), Depth));
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CountWidth'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CountWidth'(1);
            end
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter
// Round-robin arbiter sharing one downstream bus host port between NrHosts
// requesters. One request is forwarded at a time; the winning host ID is
// queued in order so each downstream response returns to its issuer.
// Ports:
//   clk_i, rst_i          : clock and synchronous active-high reset
//   host_*_i / host_*_o   : per-host request (req/addr/we/be/wdata), grant,
//                           and response (rvalid/rdata/err)
//   dev_*_o / dev_*_i     : single downstream host port
//   outstanding_o         : accepted transactions still awaiting a response
//   unexpected_rvalid_o   : sticky, set by a response arriving with none pending
module bus_host_arbiter
    import bus_host_arbiter_pkg::*;
#(
    parameter int unsigned NrHosts        = 3,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned IdWidth       = calc_id_width(NrHosts),
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   host_req_i    [NrHosts],
    output logic                   host_gnt_o    [NrHosts],
    input  logic [AddrWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                   host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0] host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]   host_wdata_i  [NrHosts],
    output logic                   host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]   host_rdata_o  [NrHosts],
    output logic                   host_err_o    [NrHosts],
    output logic                   dev_req_o,
    input  logic                   dev_gnt_i,
    output logic [AddrWidth-1:0]   dev_addr_o,
    output logic                   dev_we_o,
    output logic [DataWidth/8-1:0] dev_be_o,
    output logic [DataWidth-1:0]   dev_wdata_o,
    input  logic                   dev_rvalid_i,
    input  logic [DataWidth-1:0]   dev_rdata_i,
    input  logic                   dev_err_i,
    output logic [CntWidth-1:0]    outstanding_o,
    output logic                   unexpected_rvalid_o
);

    arb_state_e         state_q, state_d;
    logic [IdWidth-1:0] ptr_q, ptr_d;
    logic [IdWidth-1:0] hold_id_q, hold_id_d;
    logic [IdWidth-1:0] winner;
    logic               winner_valid;
    logic [IdWidth:0]   scan_idx;
    logic [IdWidth-1:0] head_id;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               handshake;
    logic               unexpected_q;

    // Winner selection. In HOLD the stalled winner stays locked so its request
    // fields remain on the bus until granted. In ARB, scan from the priority
    // pointer; the sum is one bit wider so the wrap works for any NrHosts.
    always_comb begin
        winner       = '0;
        winner_valid = 1'b0;
        scan_idx     = '0;
        if (state_q == HOLD) begin
            winner       = hold_id_q;
            winner_valid = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NrHosts; i++) begin
                scan_idx = {1'b0, ptr_q} + (IdWidth + 1)'(i);
                if (scan_idx >= (IdWidth + 1)'(NrHosts)) begin
                    scan_idx = scan_idx - (IdWidth + 1)'(NrHosts);
                end
                if (!winner_valid && host_req_i[scan_idx[IdWidth-1:0]]) begin
                    winner       = scan_idx[IdWidth-1:0];
                    winner_valid = 1'b1;
                end
            end
        end
    end

    // Outputs are held quiet during reset so nothing leaks out before the
    // FIFO and FSM have actually cleared.
    assign dev_req_o = winner_valid & ~fifo_full & ~rst_i;
    assign handshake = dev_req_o & dev_gnt_i;
    assign fifo_pop  = dev_rvalid_i & ~fifo_empty & ~rst_i;

    // Forward the winner's request fields combinationally.
    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (winner_valid && !rst_i) begin
            dev_addr_o  = host_addr_i[winner];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = host_be_i[winner];
            dev_wdata_o = host_wdata_i[winner];
        end
    end

    // Only the winner sees the downstream grant.
    always_comb begin
        for (int unsigned i = 0; i < NrHosts; i++) begin
            host_gnt_o[i] = 1'b0;
        end
        if (handshake) begin
            host_gnt_o[winner] = 1'b1;
        end
    end

    // Route the response to the host at the head of the ID FIFO; every other
    // host sees zeros.
    always_comb begin
        for (int unsigned i = 0; i < NrHosts; i++) begin
            host_rvalid_o[i] = 1'b0;
            host_rdata_o[i]  = '0;
            host_err_o[i]    = 1'b0;
        end
        if (fifo_pop) begin
            host_rvalid_o[head_id] = 1'b1;
            host_rdata_o[head_id]  = dev_rdata_i;
            host_err_o[head_id]    = dev_err_i;
        end
    end

    // Next-state logic. A stalled request locks the winner in HOLD; the
    // handshake releases it and moves priority to the host after the winner.
    // When the FIFO is full dev_req_o is low, so neither transition fires.
    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        ptr_d     = ptr_q;
        case (state_q)
            ARB: begin
                if (dev_req_o && !dev_gnt_i) begin
                    state_d   = HOLD;
                    hold_id_d = winner;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        if (handshake) begin
            ptr_d = IdWidth'(rr_next(32'(winner), NrHosts));
        end
    end

    // FSM, hold-ID and priority-pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            hold_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            ptr_q     <= ptr_d;
        end
    end

    // Sticky flag for responses nobody asked for; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            unexpected_q <= 1'b0;
        end else if (dev_rvalid_i && fifo_empty) begin
            unexpected_q <= 1'b1;
        end
    end

    assign unexpected_rvalid_o = unexpected_q;

    bus_arb_id_fifo #(
        .Width (IdWidth),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (handshake),
        .pop   (fifo_pop),
        .wdata (winner),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding_o)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb_bus_host_arbiter
// Directed self-checking bench for bus_host_arbiter with default parameters
// (3 hosts, 32-bit address/data, 2 outstanding). Each applyStimulus call
// drives one cycle's inputs on the falling edge; outputs are then checked
// before the next rising edge.
module tb_bus_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req    [3];
    logic        host_gnt    [3];
    logic [31:0] host_addr   [3];
    logic        host_we     [3];
    logic [3:0]  host_be     [3];
    logic [31:0] host_wdata  [3];
    logic        host_rvalid [3];
    logic [31:0] host_rdata  [3];
    logic        host_err    [3];
    logic        dev_req;
    logic        dev_gnt;
    logic [31:0] dev_addr;
    logic        dev_we;
    logic [3:0]  dev_be;
    logic [31:0] dev_wdata;
    logic        dev_rvalid;
    logic [31:0] dev_rdata;
    logic        dev_err;
    logic [1:0]  outstanding;
    logic        unexpected;

    logic [2:0]  gnt_vec;
    logic [2:0]  rvalid_vec;
    logic [2:0]  err_vec;

    int checks   = 0;
    int failures = 0;

    assign gnt_vec    = {host_gnt[2], host_gnt[1], host_gnt[0]};
    assign rvalid_vec = {host_rvalid[2], host_rvalid[1], host_rvalid[0]};
    assign err_vec    = {host_err[2], host_err[1], host_err[0]};

    always #5 clk = ~clk;

    bus_host_arbiter dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .host_req_i          (host_req),
        .host_gnt_o          (host_gnt),
        .host_addr_i         (host_addr),
        .host_we_i           (host_we),
        .host_be_i           (host_be),
        .host_wdata_i        (host_wdata),
        .host_rvalid_o       (host_rvalid),
        .host_rdata_o        (host_rdata),
        .host_err_o          (host_err),
        .dev_req_o           (dev_req),
        .dev_gnt_i           (dev_gnt),
        .dev_addr_o          (dev_addr),
        .dev_we_o            (dev_we),
        .dev_be_o            (dev_be),
        .dev_wdata_o         (dev_wdata),
        .dev_rvalid_i        (dev_rvalid),
        .dev_rdata_i         (dev_rdata),
        .dev_err_i           (dev_err),
        .outstanding_o       (outstanding),
        .unexpected_rvalid_o (unexpected)
    );

    // One cycle of stimulus: wait for the falling edge, drive, let it settle.
    task automatic applyStimulus(input logic [2:0] req, input logic gnt, input logic rvalid,
                                 input logic [31:0] rdata, input logic err, input logic rs);
        @(negedge clk);
        rst         = rs;
        host_req[0] = req[0];
        host_req[1] = req[1];
        host_req[2] = req[2];
        dev_gnt     = gnt;
        dev_rvalid  = rvalid;
        dev_rdata   = rdata;
        dev_err     = err;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int prev;
        rst        = 1'b1;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            host_req[i]   = 1'b0;
            host_addr[i]  = 32'h100 * 32'(i + 1);
            host_we[i]    = (i == 1);
            host_be[i]    = 4'(1 << i);
            host_wdata[i] = 32'hD000_0000 + 32'(i);
        end
        $display("[TB] start");

        // Reset held for two cycles with every host requesting.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(3'b111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            checkOutput("rst_gnt", 32'(gnt_vec), 32'h0);
            checkOutput("rst_dev_req", 32'(dev_req), 32'h0);
            checkOutput("rst_outstanding", 32'(outstanding), 32'h0);
            checkOutput("rst_unexpected", 32'(unexpected), 32'h0);
            checkOutput("rst_dev_addr", dev_addr, 32'h0);
        end

        // Round robin with every host requesting; response one cycle later.
        for (int k = 0; k < 6; k++) begin
            prev = (k + 2) % 3;
            applyStimulus(3'b111, 1'b1, (k > 0), 32'hA000_0000 + 32'(prev), 1'b0, 1'b0);
            checkOutput("rr_gnt", 32'(gnt_vec), 32'(1 << (k % 3)));
            checkOutput("rr_dev_addr", dev_addr, 32'h100 * 32'((k % 3) + 1));
            checkOutput("rr_outstanding", 32'(outstanding), (k > 0) ? 32'h1 : 32'h0);
            if (k > 0) begin
                checkOutput("rr_rvalid", 32'(rvalid_vec), 32'(1 << prev));
                checkOutput("rr_rdata", host_rdata[prev], 32'hA000_0000 + 32'(prev));
            end
        end
        applyStimulus(3'b000, 1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b0);
        checkOutput("rr_drain_gnt", 32'(gnt_vec), 32'h0);
        checkOutput("rr_drain_rvalid", 32'(rvalid_vec), 32'h4);
        checkOutput("rr_drain_rdata", host_rdata[2], 32'hA000_0002);
        checkOutput("rr_nonhead_rdata", host_rdata[0], 32'h0);

        // Stall: host1 waits three cycles, host0 arrives late, host1 still wins.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("stall_dev_req", 32'(dev_req), 32'h1);
            checkOutput("stall_gnt", 32'(gnt_vec), 32'h0);
            checkOutput("stall_addr", dev_addr, 32'h200);
        end
        checkOutput("stall_outstanding", 32'(outstanding), 32'h0);
        checkOutput("stall_we", 32'(dev_we), 32'h1);
        checkOutput("stall_be", 32'(dev_be), 32'h2);
        checkOutput("stall_wdata", dev_wdata, 32'hD000_0001);
        applyStimulus(3'b011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("hold_addr", dev_addr, 32'h200);
        checkOutput("hold_gnt", 32'(gnt_vec), 32'h0);
        applyStimulus(3'b011, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("hold_release_gnt", 32'(gnt_vec), 32'h2);
        checkOutput("hold_release_addr", dev_addr, 32'h200);
        applyStimulus(3'b001, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b0);
        checkOutput("after_hold_gnt", 32'(gnt_vec), 32'h1);
        checkOutput("after_hold_addr", dev_addr, 32'h100);
        checkOutput("after_hold_rvalid", 32'(rvalid_vec), 32'h2);
        checkOutput("after_hold_rdata", host_rdata[1], 32'hA000_0001);
        applyStimulus(3'b000, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0);
        checkOutput("after_hold_rvalid0", 32'(rvalid_vec), 32'h1);
        checkOutput("after_hold_dev_req", 32'(dev_req), 32'h0);

        // FIFO full: two grants with no response (priority now at host1).
        applyStimulus(3'b110, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full_outstanding0", 32'(outstanding), 32'h0);
        checkOutput("full_gnt1", 32'(gnt_vec), 32'h2);
        applyStimulus(3'b100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full_gnt2", 32'(gnt_vec), 32'h4);
        checkOutput("full_outstanding1", 32'(outstanding), 32'h1);
        applyStimulus(3'b001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full_dev_req", 32'(dev_req), 32'h0);
        checkOutput("full_gnt_none", 32'(gnt_vec), 32'h0);
        checkOutput("full_outstanding2", 32'(outstanding), 32'h2);
        applyStimulus(3'b001, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b0);
        checkOutput("full_pop_dev_req", 32'(dev_req), 32'h0);
        checkOutput("full_pop_rvalid", 32'(rvalid_vec), 32'h2);
        checkOutput("full_pop_rdata", host_rdata[1], 32'hA000_0001);
        checkOutput("full_pop_outstanding", 32'(outstanding), 32'h2);

        // Simultaneous push (host0) and pop (host2, error response).
        applyStimulus(3'b001, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 1'b0);
        checkOutput("pp_outstanding", 32'(outstanding), 32'h1);
        checkOutput("pp_dev_req", 32'(dev_req), 32'h1);
        checkOutput("pp_gnt", 32'(gnt_vec), 32'h1);
        checkOutput("pp_rvalid", 32'(rvalid_vec), 32'h4);
        checkOutput("pp_err", 32'(err_vec), 32'h4);
        checkOutput("pp_rdata", host_rdata[2], 32'hA000_0002);
        applyStimulus(3'b000, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0);
        checkOutput("pp_outstanding_kept", 32'(outstanding), 32'h1);
        checkOutput("pp_next_rvalid", 32'(rvalid_vec), 32'h1);
        checkOutput("pp_next_err", 32'(err_vec), 32'h0);
        checkOutput("pp_next_rdata", host_rdata[0], 32'hA000_0000);

        // Unexpected response with the FIFO empty.
        applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("unx_outstanding", 32'(outstanding), 32'h0);
        checkOutput("unx_flag_clear", 32'(unexpected), 32'h0);
        applyStimulus(3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("unx_no_rvalid", 32'(rvalid_vec), 32'h0);
        checkOutput("unx_flag_before_edge", 32'(unexpected), 32'h0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("unx_flag_sticky", 32'(unexpected), 32'h1);
        end

        // Reset with one transaction in flight; its late response is unexpected.
        applyStimulus(3'b001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mid_gnt", 32'(gnt_vec), 32'h1);
        applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("mid_rst_outstanding", 32'(outstanding), 32'h1);
        checkOutput("mid_rst_flag", 32'(unexpected), 32'h1);
        applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post_rst_outstanding", 32'(outstanding), 32'h0);
        checkOutput("post_rst_flag", 32'(unexpected), 32'h0);
        applyStimulus(3'b000, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0);
        checkOutput("late_resp_rvalid", 32'(rvalid_vec), 32'h0);
        applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("late_resp_flag", 32'(unexpected), 32'h1);
        checkOutput("late_resp_outstanding", 32'(outstanding), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
